// File: rtl/soc_run_monitor_pkg.sv
// -----------------------------------------------------------------------------
// monitor_types
//   Shared types and constants for the SoC run monitor.
//   - monitor_state_t : run-monitor FSM states
//   - check_entry_t   : one expected-write table entry {valid, addr, data}
//   - HALT_J_SELF     : the "j self" word the reference program ends on
//   - sat_inc8        : saturating 8-bit increment used by the error counter
// -----------------------------------------------------------------------------
package monitor_types;

  // Instruction word that parks the MIPS core in a jump-to-self loop.
  localparam logic [31:0] HALT_J_SELF = 32'h0800_001F;

  // Field widths of a table entry. The monitor's ADDR_BITS / DATA_W
  // parameters default to these and must be kept equal to them.
  localparam int CHK_ADDR_BITS = 10;
  localparam int CHK_DATA_W    = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_DONE    = 2'd2,
    ST_TIMEOUT = 2'd3
  } monitor_state_t;

  typedef struct packed {
    logic                     valid;
    logic [CHK_ADDR_BITS-1:0] addr;
    logic [CHK_DATA_W-1:0]    data;
  } check_entry_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/soc_run_monitor_match.sv
// -----------------------------------------------------------------------------
// monitor_match
//   Combinational priority matcher. Finds the lowest-index valid table entry
//   whose address equals the snooped dmem address.
//   Ports:
//     i_table         : expected-write table, NUM_CHECKS entries
//     i_addr          : low address bits of the current dmem write
//     o_match         : some valid entry has this address
//     o_match_idx     : index of the lowest matching entry
//     o_expected_data : expected data of that entry
// -----------------------------------------------------------------------------
module monitor_match
  import monitor_types::*;
#(
  parameter int NUM_CHECKS = 8,
  parameter int IDX_W      = 3
) (
  input  check_entry_t             i_table [NUM_CHECKS],
  input  logic [CHK_ADDR_BITS-1:0] i_addr,
  output logic                     o_match,
  output logic [IDX_W-1:0]         o_match_idx,
  output logic [CHK_DATA_W-1:0]    o_expected_data
);

  always_comb begin
    // NOTE: every output gets a default before the loop, so a cycle with no
    // match cannot leave any of them unassigned and infer a latch.
    o_match         = 1'b0;
    o_match_idx     = '0;
    o_expected_data = '0;
    // Walk from the top down: the last hit assigned is the lowest index,
    // which is how duplicate addresses are resolved.
    for (int i = NUM_CHECKS - 1; i >= 0; i--) begin
      if (i_table[i].valid && (i_table[i].addr == i_addr)) begin
        o_match         = 1'b1;
        o_match_idx     = IDX_W'(i);
        o_expected_data = i_table[i].data;
      end
    end
  end

endmodule

// File: rtl/soc_run_monitor.sv
// -----------------------------------------------------------------------------
// soc_run_monitor
//   Hardware pass/fail checker that sits beside the MIPS SoC. It snoops the
//   fetched instruction and data-memory writes, compares the writes against a
//   runtime-loaded table of expected (address, data) pairs, counts executed
//   instructions, stops on the halt instruction (checking a final register
//   value) and forces a timeout if the program runs too long.
//   Ports:
//     clock, reset          : rising-edge clock, async active-low reset
//     start                 : pulse, clears results and enters RUN
//     cfg_we/idx/valid/addr/data : table write port (ignored while in RUN)
//     final_expected/value  : expected and live final register value
//     instruction, dmem_we, alu_out, dmem_wd : snooped datapath signals
//     busy, done, timeout, pass : run status
//     instr_count, err_count, hit_mask, fail_idx, fail_data : run results
// -----------------------------------------------------------------------------
module soc_run_monitor
  import monitor_types::*;
#(
  parameter int          NUM_CHECKS     = 8,
  parameter int          ADDR_BITS      = CHK_ADDR_BITS,
  parameter int          DATA_W         = CHK_DATA_W,
  parameter int          CNT_W          = 16,
  parameter logic [31:0] HALT_INSTR     = HALT_J_SELF,
  parameter int          TIMEOUT_CYCLES = 4096,
  parameter int          IDX_W          = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  cfg_we,
  input  logic [IDX_W-1:0]      cfg_idx,
  input  logic                  cfg_valid,
  input  logic [ADDR_BITS-1:0]  cfg_addr,
  input  logic [DATA_W-1:0]     cfg_data,
  input  logic [DATA_W-1:0]     final_expected,
  input  logic [DATA_W-1:0]     final_value,
  input  logic [31:0]           instruction,
  input  logic                  dmem_we,
  input  logic [31:0]           alu_out,
  input  logic [DATA_W-1:0]     dmem_wd,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout,
  output logic                  pass,
  output logic [CNT_W-1:0]      instr_count,
  output logic [7:0]            err_count,
  output logic [NUM_CHECKS-1:0] hit_mask,
  output logic [IDX_W-1:0]      fail_idx,
  output logic [DATA_W-1:0]     fail_data
);

  // Wide enough to hold TIMEOUT_CYCLES itself.
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  // ---------------------------------------------------------------------------
  // Expected-write table
  // ---------------------------------------------------------------------------
  logic [NUM_CHECKS-1:0] r_valid;
  logic [ADDR_BITS-1:0]  r_addr [NUM_CHECKS];
  logic [DATA_W-1:0]     r_data [NUM_CHECKS];
  check_entry_t          w_table [NUM_CHECKS];

  monitor_state_t        r_state;
  logic                  w_cfg_ok;

  // The table may only change while no run is being checked.
  assign w_cfg_ok = cfg_we && (r_state != ST_RUN) && (int'(cfg_idx) < NUM_CHECKS);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_valid <= '0;
    end else if (w_cfg_ok) begin
      // NOTE: sequential state is always updated with <=, so every flop
      // samples the pre-edge value regardless of statement order.
      r_valid[cfg_idx] <= cfg_valid;
    end
  end

  // NOTE: the address/data storage is deliberately not reset; an entry's
  // contents are meaningless unless its valid bit is set, and only the
  // valid bits are cleared by reset.
  always_ff @(posedge clock) begin
    if (w_cfg_ok) begin
      r_addr[cfg_idx] <= cfg_addr;
      r_data[cfg_idx] <= cfg_data;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CHECKS; i++) begin
      w_table[i].valid = r_valid[i];
      w_table[i].addr  = r_addr[i];
      w_table[i].data  = r_data[i];
    end
  end

  // ---------------------------------------------------------------------------
  // Address matcher
  // ---------------------------------------------------------------------------
  logic              w_match;
  logic [IDX_W-1:0]  w_match_idx;
  logic [DATA_W-1:0] w_expected_data;
  logic              w_unused_addr_hi;

  // Only the word-addressed dmem range is compared; upper bits are ignored.
  assign w_unused_addr_hi = ^alu_out[31:ADDR_BITS];

  monitor_match #(
    .NUM_CHECKS (NUM_CHECKS),
    .IDX_W      (IDX_W)
  ) u_match (
    .i_table         (w_table),
    .i_addr          (alu_out[ADDR_BITS-1:0]),
    .o_match         (w_match),
    .o_match_idx     (w_match_idx),
    .o_expected_data (w_expected_data)
  );

  // ---------------------------------------------------------------------------
  // Run FSM, counters and result capture
  // ---------------------------------------------------------------------------
  logic [TO_W-1:0]       r_cycle_cnt;
  logic [CNT_W-1:0]      r_instr_count;
  logic [7:0]            r_err_count;
  logic [NUM_CHECKS-1:0] r_hit_mask;
  logic [IDX_W-1:0]      r_fail_idx;
  logic [DATA_W-1:0]     r_fail_data;
  logic                  r_done;
  logic                  r_timeout;
  logic                  r_pass;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_IDLE;
      r_cycle_cnt   <= '0;
      r_instr_count <= '0;
      r_err_count   <= '0;
      r_hit_mask    <= '0;
      r_fail_idx    <= '0;
      r_fail_data   <= '0;
      r_done        <= 1'b0;
      r_timeout     <= 1'b0;
      r_pass        <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (instruction == HALT_INSTR) begin
            // Halt wins over everything else in this cycle, including a
            // simultaneous dmem write and the timeout.
            r_state <= ST_DONE;
            r_done  <= 1'b1;
            r_pass  <= (r_err_count == 8'd0) &&
                       ((r_valid & ~r_hit_mask) == '0) &&
                       (final_value == final_expected);
          end else begin
            if (r_instr_count != '1) begin
              r_instr_count <= r_instr_count + CNT_W'(1);
            end

            if (dmem_we && w_match) begin
              if (dmem_wd == w_expected_data) begin
                r_hit_mask[w_match_idx] <= 1'b1;
              end else begin
                r_err_count <= sat_inc8(r_err_count);
                // Only the first mismatch of a run is captured.
                if (r_err_count == 8'd0) begin
                  r_fail_idx  <= w_match_idx;
                  r_fail_data <= dmem_wd;
                end
              end
            end

            // This is the TIMEOUT_CYCLES-th RUN cycle without a halt.
            if (r_cycle_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
              r_state   <= ST_TIMEOUT;
              r_timeout <= 1'b1;
              r_pass    <= 1'b0;
            end else begin
              r_cycle_cnt <= r_cycle_cnt + TO_W'(1);
            end
          end
        end

        // IDLE, DONE and TIMEOUT hold their results until the next start.
        default: begin
          if (start) begin
            r_state       <= ST_RUN;
            r_cycle_cnt   <= '0;
            r_instr_count <= '0;
            r_err_count   <= '0;
            r_hit_mask    <= '0;
            r_fail_idx    <= '0;
            r_fail_data   <= '0;
            r_done        <= 1'b0;
            r_timeout     <= 1'b0;
            r_pass        <= 1'b0;
          end
        end
      endcase
    end
  end

  assign busy        = (r_state == ST_RUN);
  assign done        = r_done;
  assign timeout     = r_timeout;
  assign pass        = r_pass;
  assign instr_count = r_instr_count;
  assign err_count   = r_err_count;
  assign hit_mask    = r_hit_mask;
  assign fail_idx    = r_fail_idx;
  assign fail_data   = r_fail_data;

endmodule

// File: tb/tb_soc_run_monitor.sv
// -----------------------------------------------------------------------------
// tb_soc_run_monitor
//   Directed bench for soc_run_monitor: a vector table for the reference
//   program plus hand-written sequences for mismatch, missing write, bad final
//   value, halt-with-write, cfg during RUN, timeout, mid-run reset and
//   duplicate-address resolution.
// -----------------------------------------------------------------------------
module tb_soc_run_monitor;
  import monitor_types::*;

  localparam int NC = 8;
  localparam int AB = 10;
  localparam int DW = 32;
  localparam int CW = 16;
  localparam int TO = 16;
  localparam int IW = 3;
  localparam logic [31:0] HALT = 32'h0800_001F;
  localparam logic [31:0] NOP  = 32'h0000_0000;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic          cfg_we;
  logic [IW-1:0] cfg_idx;
  logic          cfg_valid;
  logic [AB-1:0] cfg_addr;
  logic [DW-1:0] cfg_data;
  logic [DW-1:0] final_expected;
  logic [DW-1:0] final_value;
  logic [31:0]   instruction;
  logic          dmem_we;
  logic [31:0]   alu_out;
  logic [DW-1:0] dmem_wd;
  logic          busy;
  logic          done;
  logic          timeout;
  logic          pass;
  logic [CW-1:0] instr_count;
  logic [7:0]    err_count;
  logic [NC-1:0] hit_mask;
  logic [IW-1:0] fail_idx;
  logic [DW-1:0] fail_data;

  always #5 clock = ~clock;

  soc_run_monitor #(
    .NUM_CHECKS     (NC),
    .ADDR_BITS      (AB),
    .DATA_W         (DW),
    .CNT_W          (CW),
    .HALT_INSTR     (HALT),
    .TIMEOUT_CYCLES (TO),
    .IDX_W          (IW)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .start          (start),
    .cfg_we         (cfg_we),
    .cfg_idx        (cfg_idx),
    .cfg_valid      (cfg_valid),
    .cfg_addr       (cfg_addr),
    .cfg_data       (cfg_data),
    .final_expected (final_expected),
    .final_value    (final_value),
    .instruction    (instruction),
    .dmem_we        (dmem_we),
    .alu_out        (alu_out),
    .dmem_wd        (dmem_wd),
    .busy           (busy),
    .done           (done),
    .timeout        (timeout),
    .pass           (pass),
    .instr_count    (instr_count),
    .err_count      (err_count),
    .hit_mask       (hit_mask),
    .fail_idx       (fail_idx),
    .fail_data      (fail_data)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic        halt;
    logic [7:0]  exp_err;
    logic [7:0]  exp_hit;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t        vecs [11];
  logic [9:0]  ref_addr [8];
  logic [31:0] ref_data [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Advance one edge; outputs are then sampled 1 ns after it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic cfg_write(input int idx, input logic v, input logic [9:0] a, input logic [31:0] d);
    cfg_we    = 1'b1;
    cfg_idx   = IW'(idx);
    cfg_valid = v;
    cfg_addr  = a;
    cfg_data  = d;
    tick();
    cfg_we    = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Drive the reference program's writes; skip_idx omits one, bad_idx
  // replaces one write's data with bad_data (-1 disables either).
  task automatic run_ref(input int skip_idx, input int bad_idx, input logic [31:0] bad_data);
    for (int i = 0; i < 8; i++) begin
      if (i != skip_idx) begin
        dmem_we = 1'b1;
        alu_out = {22'd0, ref_addr[i]};
        dmem_wd = (i == bad_idx) ? bad_data : ref_data[i];
        tick();
      end
    end
    dmem_we = 1'b0;
  endtask

  task automatic do_halt();
    instruction = HALT;
    tick();
    instruction = NOP;
  endtask

  initial begin
    ref_addr = '{10'h1FC, 10'h1F8, 10'h1F4, 10'h1F0, 10'h1EC, 10'h1E8, 10'h1E4, 10'h1E0};
    ref_data = '{32'h4, 32'hC, 32'h3, 32'h58, 32'h2, 32'h58, 32'h1, 32'h58};

    //            we    alu_out        data     halt  err    hit    cnt
    vecs[0]  = '{1'b1, 32'h1000_05FC, 32'h4,  1'b0, 8'd0, 8'h01, 16'd1};
    vecs[1]  = '{1'b1, 32'h0000_01F8, 32'hC,  1'b0, 8'd0, 8'h03, 16'd2};
    vecs[2]  = '{1'b1, 32'h0000_01F4, 32'h3,  1'b0, 8'd0, 8'h07, 16'd3};
    vecs[3]  = '{1'b1, 32'h0000_01F0, 32'h58, 1'b0, 8'd0, 8'h0F, 16'd4};
    vecs[4]  = '{1'b1, 32'h0000_0100, 32'h99, 1'b0, 8'd0, 8'h0F, 16'd5};
    vecs[5]  = '{1'b0, 32'h0000_01EC, 32'h77, 1'b0, 8'd0, 8'h0F, 16'd6};
    vecs[6]  = '{1'b1, 32'h0000_01EC, 32'h2,  1'b0, 8'd0, 8'h1F, 16'd7};
    vecs[7]  = '{1'b1, 32'h0000_01E8, 32'h58, 1'b0, 8'd0, 8'h3F, 16'd8};
    vecs[8]  = '{1'b1, 32'h0000_01E4, 32'h1,  1'b0, 8'd0, 8'h7F, 16'd9};
    vecs[9]  = '{1'b1, 32'h0000_01E0, 32'h58, 1'b0, 8'd0, 8'hFF, 16'd10};
    vecs[10] = '{1'b0, 32'h0000_0000, 32'h0,  1'b1, 8'd0, 8'hFF, 16'd10};

    reset = 1'b0; start = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_valid = 1'b0;
    cfg_addr = '0; cfg_data = '0; final_expected = 32'h18; final_value = 32'h18;
    instruction = NOP; dmem_we = 1'b0; alu_out = '0; dmem_wd = '0;

    // ---- reset state ----
    #12;
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst pass", pass, 0);
    check("rst timeout", timeout, 0);
    check("rst instr_count", instr_count, 0);
    check("rst err_count", err_count, 0);
    check("rst hit_mask", hit_mask, 0);
    reset = 1'b1;

    // ---- reference program via vector table ----
    for (int i = 0; i < 8; i++) cfg_write(i, 1'b1, ref_addr[i], ref_data[i]);
    do_start();
    check("ref busy", busy, 1);
    for (int i = 0; i < 11; i++) begin
      dmem_we     = vecs[i].we;
      alu_out     = vecs[i].addr;
      dmem_wd     = vecs[i].data;
      instruction = vecs[i].halt ? HALT : NOP;
      tick();
      check($sformatf("vec%0d err_count", i), err_count, vecs[i].exp_err);
      check($sformatf("vec%0d hit_mask", i), hit_mask, vecs[i].exp_hit);
      check($sformatf("vec%0d instr_count", i), instr_count, vecs[i].exp_cnt);
    end
    dmem_we = 1'b0; instruction = NOP;
    check("ref done", done, 1);
    check("ref pass", pass, 1);
    check("ref busy after halt", busy, 0);
    tick();
    check("ref done held", done, 1);
    check("ref instr_count held", instr_count, 10);

    // ---- single mismatch at 1F4 ----
    do_start();
    check("mis cleared done", done, 0);
    check("mis cleared hit", hit_mask, 0);
    check("mis cleared pass", pass, 0);
    run_ref(-1, 2, 32'h5);
    check("mis err_count", err_count, 1);
    check("mis fail_idx", fail_idx, 2);
    check("mis fail_data", fail_data, 32'h5);
    check("mis hit_mask", hit_mask, 8'hFB);
    do_halt();
    check("mis done", done, 1);
    check("mis pass", pass, 0);

    // ---- missing 1E0 write ----
    do_start();
    check("skip err cleared", err_count, 0);
    run_ref(7, -1, 32'h0);
    check("skip hit_mask", hit_mask, 8'h7F);
    do_halt();
    check("skip pass", pass, 0);
    check("skip err_count", err_count, 0);

    // ---- bad final value ----
    final_value = 32'h17;
    do_start();
    run_ref(-1, -1, 32'h0);
    do_halt();
    check("final hit_mask", hit_mask, 8'hFF);
    check("final err_count", err_count, 0);
    check("final done", done, 1);
    check("final pass", pass, 0);
    final_value = 32'h18;

    // ---- cfg write during RUN, then halt together with a wrong write ----
    do_start();
    cfg_write(0, 1'b1, 10'h1FC, 32'h777);
    run_ref(-1, -1, 32'h0);
    check("cfgrun err_count", err_count, 0);
    check("cfgrun hit_mask", hit_mask, 8'hFF);
    dmem_we = 1'b1; alu_out = 32'h0000_01FC; dmem_wd = 32'hBAD;
    do_halt();
    dmem_we = 1'b0;
    check("haltwr err_count", err_count, 0);
    check("haltwr done", done, 1);
    check("haltwr pass", pass, 1);
    check("haltwr instr_count", instr_count, 9);

    // ---- timeout after 16 RUN cycles ----
    do_start();
    for (int i = 0; i < 15; i++) tick();
    check("to not yet", timeout, 0);
    check("to busy before", busy, 1);
    tick();
    check("to timeout", timeout, 1);
    check("to done", done, 0);
    check("to pass", pass, 0);
    check("to busy", busy, 0);
    tick(); tick();
    check("to held", timeout, 1);

    // ---- asynchronous reset mid-run ----
    do_start();
    dmem_we = 1'b1; alu_out = 32'h0000_01FC; dmem_wd = 32'h4;
    tick();
    dmem_we = 1'b0;
    tick();
    check("mid pre hit", hit_mask, 8'h01);
    #2 reset = 1'b0;
    #1;
    check("mid busy", busy, 0);
    check("mid hit_mask", hit_mask, 0);
    check("mid instr_count", instr_count, 0);
    #2 reset = 1'b1;
    tick();
    check("mid idle", busy, 0);
    do_start();
    do_halt();
    check("empty done", done, 1);
    check("empty pass", pass, 1);
    check("empty instr_count", instr_count, 0);

    // ---- duplicate addresses resolve to the lowest index ----
    cfg_write(3, 1'b1, 10'h02A, 32'h11);
    cfg_write(5, 1'b1, 10'h02A, 32'h22);
    do_start();
    dmem_we = 1'b1; alu_out = 32'h0000_002A;
    dmem_wd = 32'h22; tick();
    check("dup err1", err_count, 1);
    check("dup fail_idx", fail_idx, 3);
    check("dup fail_data", fail_data, 32'h22);
    check("dup hit none", hit_mask, 0);
    dmem_wd = 32'h11; tick();
    check("dup hit3", hit_mask, 8'h08);
    dmem_wd = 32'h33; tick();
    dmem_we = 1'b0;
    check("dup err2", err_count, 2);
    check("dup fail_data first", fail_data, 32'h22);
    do_halt();
    check("dup done", done, 1);
    check("dup pass", pass, 0);
    check("dup instr_count", instr_count, 3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/soc_run_monitor.md
Name: soc_run_monitor

Overview:
- Synthesizable run monitor for the MIPS SoC. Sits beside `soc` and snoops `instruction`, `dmem_we`, `alu_out` and `dmem_wd`.
- Checks data-memory writes against a table of up to NUM_CHECKS expected (address, data) pairs, loaded at runtime. Counts instructions, detects the halt instruction, checks a final register value and enforces a cycle timeout.
- Reports pass/fail in hardware, so the same check runs in simulation and on the board.

Parameters:
- NUM_CHECKS, 8, number of expected-write table entries
- ADDR_BITS, 10, low alu_out bits compared as the dmem address
- DATA_W, 32, data width of writes and final value
- CNT_W, 16, instruction counter width
- HALT_INSTR, 32'h0800001F, instruction word that ends the program
- TIMEOUT_CYCLES, 4096, RUN cycles before a forced timeout
- IDX_W, $clog2(NUM_CHECKS), table index width (derived)

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  pulse: clear results, enter RUN
- cfg_we  in  1  table write strobe
- cfg_idx  in  IDX_W  table entry index
- cfg_valid  in  1  entry enable
- cfg_addr  in  ADDR_BITS  expected write address
- cfg_data  in  DATA_W  expected write data
- final_expected  in  DATA_W  expected final register value
- final_value  in  DATA_W  live final register value from the datapath
- instruction  in  32  current fetched instruction
- dmem_we  in  1  dmem write enable
- alu_out  in  32  dmem address
- dmem_wd  in  DATA_W  dmem write data
- busy  out  1  in RUN
- done  out  1  halt reached
- timeout  out  1  timeout reached
- pass  out  1  run passed
- instr_count  out  CNT_W  instructions executed
- err_count  out  8  data mismatches, saturating
- hit_mask  out  NUM_CHECKS  entries that matched at least once
- fail_idx  out  IDX_W  entry of the first mismatch
- fail_data  out  DATA_W  data of the first mismatch

Behaviour:
- Reset (reset=0, async):
  - State is IDLE.
  - All outputs are 0.
  - All table valid bits are cleared.
- States: IDLE, RUN, DONE, TIMEOUT. The state encoding is an enum in the package.
- IDLE/DONE/TIMEOUT + start:
  - On the next edge, enter RUN.
  - Clear instr_count, err_count, hit_mask, fail_idx, fail_data, pass, done and timeout.
  - The table is retained.
- cfg_we:
  - Writes entry cfg_idx = {cfg_valid, cfg_addr, cfg_data}.
  - Accepted only outside RUN; ignored in RUN.
  - Writes to cfg_idx >= NUM_CHECKS are ignored.
- RUN, each cycle, with halt priority:
  1. instruction == HALT_INSTR:
     - Next state is DONE and done=1.
     - pass = (err_count==0) && (hit_mask covers every valid entry) && (final_value==final_expected).
     - A dmem write in the same cycle is ignored and is not counted.
  2. Otherwise:
     - instr_count increments, saturating at all-ones.
     - If dmem_we is set, the write is matched against the table (see matching).
  3. When the RUN cycle count reaches TIMEOUT_CYCLES and no halt has occurred: next state is TIMEOUT, timeout=1, pass=0.
- Matching:
  - The lowest-index valid entry with addr == alu_out[ADDR_BITS-1:0] matches; duplicate addresses resolve to the lowest index.
  - Data equal: set hit_mask[idx].
  - Data not equal: err_count increments, saturating at 255. On the first error only, capture fail_idx=idx and fail_data=dmem_wd.
  - Writes to unmatched addresses are ignored.
  - A repeat write to an already-hit entry is still checked, and hit stays set.
- Latency:
  - Results are registered; err_count and hit_mask are visible 1 cycle after the write.
  - done/pass are visible 1 cycle after halt.
- DONE/TIMEOUT hold all results until start or reset.
- busy = (state == RUN).
- A reset during RUN returns to IDLE immediately and clears the table.

Decomposition:
- Package `monitor_types`:
  - monitor_state_t enum
  - check_entry_t packed struct {valid, addr, data}
  - constant HALT_J_SELF = 32'h0800001F
- Sub-module `monitor_match`: combinational priority matcher.
  - Inputs: table array, alu_out slice.
  - Outputs: match, match_idx, expected_data.
- The top level holds the FSM, counters, table registers and capture logic.

Test Plan:
- Reference program, all writes correct:
  - Load 8 entries: 1FC→4, 1F8→C, 1F4→3, 1F0→58, 1EC→2, 1E8→58, 1E4→1, 1E0→58.
  - final_expected=0x18. Drive those writes, then HALT with final_value=0x18.
  - Required: done=1, pass=1, err_count=0, hit_mask=8'hFF, instr_count = non-halt cycles.
- Single mismatch:
  - Same setup, but write 1F4 with data 0x5.
  - Required: err_count=1, fail_idx=2, fail_data=0x5, hit_mask[2]=0, pass=0 after halt.
- Missing write / bad final value:
  - Skip the 1E0 write: pass=0, hit_mask=8'h7F.
  - Separate run with all writes present and final_value=0x17: pass=0, err_count=0.
- Timeout:
  - TIMEOUT_CYCLES=16, never drive HALT.
  - Required: timeout=1 after 16 RUN cycles, done=0, pass=0, busy=0.
- Halt and write in the same cycle:
  - Drive dmem_we with a wrong-data 1FC write together with HALT.
  - Required: err_count unchanged, done=1.
  - A cfg_we issued during RUN leaves the table unchanged.
- Reset mid-run:
  - Drive reset=0 asynchronously between edges during RUN.
  - Required: outputs 0 immediately, IDLE.
  - A later start with no table reload and an immediate HALT gives pass=1, since there are no valid entries.
